// File: rtl/hs32_mem_arbiter.sv
// rtl/hs32_mem_arbiter.sv - Round-robin arbiter sharing one SRAM between the Wishbone host and the HS32 core
module hs32_mem_arbiter #(
  parameter int          AW        = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  output logic          wbs_ack_o,
  output logic [31:0]   wbs_dat_o,
  input  logic          core_hold_i,
  input  logic          core_stb_i,
  input  logic          core_rw_i,
  input  logic [31:0]   core_addr_i,
  input  logic [31:0]   core_dtw_i,
  output logic [31:0]   core_dtr_o,
  output logic          core_ack_o,
  output logic          ram_en_o,
  output logic [3:0]    ram_we_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [31:0]   ram_din_o,
  input  logic [31:0]   ram_dout_i
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          host_pend_q, host_pend_d;
  logic          host_we_q, host_we_d;
  logic [3:0]    host_sel_q, host_sel_d;
  logic [31:2]   host_adr_q, host_adr_d;
  logic [31:0]   host_dat_q, host_dat_d;
  logic          gnt_host_q, gnt_host_d;
  logic          last_host_q, last_host_d;
  logic          core_rw_q, core_rw_d;
  logic          ram_en_q, ram_en_d;
  logic [3:0]    ram_we_q, ram_we_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]   ram_din_q, ram_din_d;
  logic [31:0]   wbs_dat_q, wbs_dat_d;
  logic [31:0]   core_dtr_q, core_dtr_d;

  logic          host_new, host_req, core_req, pick_host;
  logic          eff_we;
  logic [3:0]    eff_sel;
  logic [31:2]   eff_adr;
  logic [31:0]   eff_dat;
  logic          eff_in_range, resp_in_range;
  logic          unused_addr_bits;

  // A strobe seen in IDLE is granted in the same cycle, so the live bus stands in for the latch.
  assign host_new  = wbs_stb_i & wbs_cyc_i & ~host_pend_q;
  assign host_req  = wbs_cyc_i & (host_pend_q | wbs_stb_i);
  assign core_req  = core_stb_i & ~core_hold_i;
  assign pick_host = host_req & (~core_req | ~last_host_q);

  assign eff_we  = host_pend_q ? host_we_q  : wbs_we_i;
  assign eff_sel = host_pend_q ? host_sel_q : wbs_sel_i;
  assign eff_adr = host_pend_q ? host_adr_q : wbs_adr_i[31:2];
  assign eff_dat = host_pend_q ? host_dat_q : wbs_dat_i;

  assign eff_in_range  = (eff_adr[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign resp_in_range = (host_adr_q[31:AW+2] == BASE_ADDR[31:AW+2]);

  assign unused_addr_bits = ^{wbs_adr_i[1:0], core_addr_i[31:AW+2], core_addr_i[1:0]};

  assign wbs_ack_o  = (state_q == ST_RESP) & gnt_host_q & wbs_cyc_i;
  assign core_ack_o = (state_q == ST_RESP) & ~gnt_host_q;
  assign wbs_dat_o  = wbs_ack_o ? (resp_in_range ? ram_dout_i : 32'h0) : wbs_dat_q;
  assign core_dtr_o = (core_ack_o & ~core_rw_q) ? ram_dout_i : core_dtr_q;

  assign ram_en_o   = ram_en_q;
  assign ram_we_o   = ram_we_q;
  assign ram_addr_o = ram_addr_q;
  assign ram_din_o  = ram_din_q;

  always_comb begin
    state_d     = state_q;
    host_pend_d = host_pend_q;
    host_we_d   = host_we_q;
    host_sel_d  = host_sel_q;
    host_adr_d  = host_adr_q;
    host_dat_d  = host_dat_q;
    gnt_host_d  = gnt_host_q;
    last_host_d = last_host_q;
    core_rw_d   = core_rw_q;
    ram_en_d    = 1'b0;
    ram_we_d    = 4'h0;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    wbs_dat_d   = wbs_dat_q;
    core_dtr_d  = core_dtr_q;

    if (!wbs_cyc_i) begin
      host_pend_d = 1'b0;
    end else if (host_new) begin
      host_pend_d = 1'b1;
      host_we_d   = wbs_we_i;
      host_sel_d  = wbs_sel_i;
      host_adr_d  = wbs_adr_i[31:2];
      host_dat_d  = wbs_dat_i;
    end

    case (state_q)
      ST_IDLE: begin
        if (host_req | core_req) begin
          gnt_host_d  = pick_host;
          last_host_d = pick_host;
          if (pick_host) begin
            if (eff_in_range) begin
              state_d    = ST_ISSUE;
              ram_en_d   = 1'b1;
              ram_we_d   = eff_we ? eff_sel : 4'h0;
              ram_addr_d = eff_adr[AW+1:2];
              ram_din_d  = eff_dat;
            end else begin
              state_d = ST_RESP;
            end
          end else begin
            state_d    = ST_ISSUE;
            core_rw_d  = core_rw_i;
            ram_en_d   = 1'b1;
            ram_we_d   = core_rw_i ? 4'hF : 4'h0;
            ram_addr_d = core_addr_i[AW+1:2];
            ram_din_d  = core_dtw_i;
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        if (wbs_ack_o) begin
          host_pend_d = 1'b0;
          wbs_dat_d   = wbs_dat_o;
        end
        if (core_ack_o & ~core_rw_q) begin
          core_dtr_d = core_dtr_o;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      host_pend_q <= 1'b0;
      host_we_q   <= 1'b0;
      host_sel_q  <= 4'h0;
      host_adr_q  <= '0;
      host_dat_q  <= 32'h0;
      gnt_host_q  <= 1'b0;
      last_host_q <= 1'b0;
      core_rw_q   <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 4'h0;
      ram_addr_q  <= '0;
      ram_din_q   <= 32'h0;
      wbs_dat_q   <= 32'h0;
      core_dtr_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      host_pend_q <= host_pend_d;
      host_we_q   <= host_we_d;
      host_sel_q  <= host_sel_d;
      host_adr_q  <= host_adr_d;
      host_dat_q  <= host_dat_d;
      gnt_host_q  <= gnt_host_d;
      last_host_q <= last_host_d;
      core_rw_q   <= core_rw_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      wbs_dat_q   <= wbs_dat_d;
      core_dtr_q  <= core_dtr_d;
    end
  end

endmodule

// File: doc/hs32_mem_arbiter.md
Name: hs32_mem_arbiter

Overview:
- Shares one single-port user-area SRAM between two requesters:
  - the Caravel Wishbone slave port, used by the host to load programs and inspect memory;
  - the HS32 core memory bus.
- Round-robin arbitration; one access in flight at a time.
- Sits in user_proj_example between the wrapper Wishbone pins, the core memory port and the SRAM macro.
- Also gates core access while the core is held (program-load window).

Parameters:
- AW, 10, SRAM word-address width (1024 words = 4 KB).
- BASE_ADDR, 32'h0000_0000, host byte-address base of the SRAM window.

Ports:
- wb_clk_i  in  1  single clock
- wb_rst_i  in  1  synchronous reset, active-high
- wbs_stb_i  in  1  Wishbone strobe
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_we_i  in  1  Wishbone write enable
- wbs_sel_i  in  4  Wishbone byte lanes
- wbs_adr_i  in  32  Wishbone byte address
- wbs_dat_i  in  32  Wishbone write data
- wbs_ack_o  out  1  Wishbone acknowledge
- wbs_dat_o  out  32  Wishbone read data
- core_hold_i  in  1  core held (driven from LA); core requests ignored while high
- core_stb_i  in  1  core request, level, held until core_ack_o
- core_rw_i  in  1  1 = write, 0 = read
- core_addr_i  in  32  core byte address; bits [AW+1:2] used
- core_dtw_i  in  32  core write data
- core_dtr_o  out  32  core read data
- core_ack_o  out  1  core acknowledge, one-cycle pulse
- ram_en_o  out  1  SRAM enable
- ram_we_o  out  4  SRAM byte write enables
- ram_addr_o  out  AW  SRAM word address
- ram_din_o  out  32  SRAM write data
- ram_dout_i  in  32  SRAM read data, valid the cycle after an enabled read

Behaviour:
- **Reset values:**
  - all outputs 0;
  - state IDLE;
  - host_pend 0;
  - last_grant = CORE, so the host wins the first contention.
- **Host request latch (host_pend):**
  - Set on any edge with wbs_stb_i & wbs_cyc_i & !host_pend; captures adr, dat, sel and we at that edge.
  - wbs_stb_i may drop after one cycle while cyc stays high; the request remains pending.
  - Cleared when the host is acked, or when wbs_cyc_i is low at any edge.
- **Host range check:** the request is in range iff wbs_adr_i[31:AW+2] == BASE_ADDR[31:AW+2].
- **Core request validity:** core_stb_i & !core_hold_i.
- **State IDLE:**
  - Only host pending → grant HOST. Only core valid → grant CORE.
  - Both → grant the opposite of last_grant.
  - On grant, last_grant is updated.
  - In-range host grant or core grant → ISSUE, with ram_* outputs registered at that edge.
  - Out-of-range host grant → RESP directly; no RAM access; read data 0.
- **State ISSUE** (one cycle):
  - ram_en_o = 1.
  - ram_we_o = latched sel for a host write; 4'b1111 for a core write; 0 for reads.
  - ram_addr_o and ram_din_o come from the granted request.
  - Always → RESP; ram_en_o and ram_we_o return to 0.
- **State RESP** (one cycle):
  - Host grant: wbs_ack_o = 1 and wbs_dat_o = ram_dout_i (0 if out of range), only if wbs_cyc_i is still high. If cyc has dropped, the ack is suppressed; a write already issued stays committed.
  - Core grant: core_ack_o = 1; core_dtr_o = ram_dout_i on reads.
  - Always → IDLE.
- **Latency** (N = first IDLE cycle with the request visible):
  - in-range access: ack in cycle N+2;
  - out-of-range host access: ack in cycle N+1;
  - losing requester under contention: ack no earlier than N+5.
- **Data outputs:** wbs_dat_o and core_dtr_o hold their last value between acks.
- **Waiting requests:** requests arriving during ISSUE or RESP wait. Core must hold core_stb_i; host is latched.
- **core_hold_i:**
  - Rising during a granted core access: that access completes normally.
  - While high: the host receives every slot.
- **Reset mid-operation:**
  - Next cycle: state IDLE, all acks and ram_en_o/ram_we_o low, host_pend cleared.
  - No partial write beyond the ISSUE cycle already taken.

Test Plan:
1. **Host load:**
   - Stimulus: hold core_hold_i = 1; host writes 32'h2400CAFE, 32'h24100005, 32'h34010001, 32'h14210001, 32'h50000000 to addresses 0, 4, 8, 12, 16, sel = 4'hF, stb pulsed for one cycle with cyc held.
   - Response: each ack at N+2; RAM words 0..4 hold those values.
   - Follow-up: host read of address 0 returns 32'h2400CAFE.
2. **Core read:**
   - Stimulus: core_hold_i = 0; core_stb_i, core_rw_i = 0, core_addr_i = 4.
   - Response: core_ack_o pulses at N+2 with core_dtr_o = 32'h24100005.
   - Core write of 32'hC0DE to address 8: ram_we_o = 4'hF in ISSUE.
3. **Contention:**
   - Stimulus: host and core request in the same IDLE cycle after reset.
   - Response: host acked at N+2, core acked at N+5.
   - Immediate repeat with both requesting: core is served first.
4. **Hold gating:**
   - Stimulus: core_hold_i = 1 with core_stb_i high for 20 cycles.
   - Response: no core_ack_o and no ram_en_o for the core; a concurrent host read completes at N+2.
5. **Out of range:**
   - Stimulus: host read at 32'h0000_1000 (AW = 10).
   - Response: ack at N+1 with data 0; ram_en_o stays 0.
   - Host write there: RAM contents unchanged.
6. **Abort and reset:**
   - Stimulus A: host write to address 0x20 with cyc dropped during ISSUE.
   - Response A: RAM word 8 written; no wbs_ack_o; host_pend cleared.
   - Stimulus B: wb_rst_i asserted in ISSUE.
   - Response B: next cycle state is IDLE with all outputs 0.
